// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment driver.
// Segment encodings are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned BCD_W  = DIGITS * NIB_W;

  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  localparam logic [SEG_W-1:0]  SEG_DASH = 7'b0111111;
  localparam logic [SEG_W-1:0]  SEG_OFF  = 7'b1111111;
  localparam logic [DIGITS-1:0] AN_OFF   = 4'b1111;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] bcd_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_OFF;
    end else if (bcd_i <= 4'd9) begin
      seg_o = SEG_DIGIT[bcd_i];
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode display driver with anti-ghosting gap
// and optional leading-zero blanking. All pin outputs are registered.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [NIB_W-1:0]  thousands,
  input  logic [NIB_W-1:0]  hundreds,
  input  logic [NIB_W-1:0]  tens,
  input  logic [NIB_W-1:0]  ones,
  input  logic              blank_lz,
  output logic [DIGITS-1:0] an,
  output logic [SEG_W-1:0]  seg,
  output logic              dp,
  output logic              frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [BCD_W-1:0]  shadow_q, shadow_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  scan_state_e       state_q, state_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              frame_done_q, frame_done_d;

  logic              wrap_c;
  logic [NIB_W-1:0]  nib_c;
  logic [DIGITS-1:0] lz_c;
  logic              blank_c;
  logic [SEG_W-1:0]  dec_seg_c;

  assign wrap_c = (cnt_q == CNT_MAX);

  // Slot timing and data path; disp only follows shadow at a slot boundary.
  always_comb begin
    cnt_d    = wrap_c ? '0 : cnt_q + CNT_W'(1);
    idx_d    = wrap_c ? idx_q + 2'd1 : idx_q;
    shadow_d = load ? {thousands, hundreds, tens, ones} : shadow_q;
    disp_d   = wrap_c ? shadow_q : disp_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= GAP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GAP:     if (cnt_q == GAP_LAST) state_d = SHOW;
      SHOW:    if (wrap_c)            state_d = GAP;
      default: state_d = GAP;
    endcase
  end

  // Digit mux and leading-zero detection: a digit blanks only if it and all higher digits are 0.
  always_comb begin
    case (idx_q)
      2'd0:    nib_c = disp_q[3:0];
      2'd1:    nib_c = disp_q[7:4];
      2'd2:    nib_c = disp_q[11:8];
      default: nib_c = disp_q[15:12];
    endcase
    lz_c[3] = (disp_q[15:12] == 4'd0);
    lz_c[2] = lz_c[3] && (disp_q[11:8] == 4'd0);
    lz_c[1] = lz_c[2] && (disp_q[7:4] == 4'd0);
    lz_c[0] = 1'b0;
    blank_c = blank_lz && lz_c[idx_q];
  end

  bcd_to_seg u_dec (
    .bcd_i   (nib_c),
    .blank_i (blank_c),
    .seg_o   (dec_seg_c)
  );

  always_comb begin
    an_d         = AN_OFF;
    seg_d        = SEG_OFF;
    frame_done_d = (idx_q == 2'd3) && wrap_c;
    if (state_q == SHOW) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = dec_seg_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
  assign dp         = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed scenarios plus random traffic, checked every
// cycle against a model that derives slot/digit position from elapsed cycles.
module tb_seven_seg_scanner;

  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] thousands = 4'd0, hundreds = 4'd0, tens = 4'd0, ones = 4'd0;
  logic       blank_lz = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .thousands  (thousands),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model state: k = edges since reset release; shadow/disp as the user sees them.
  int          k = 0;
  logic [15:0] m_shadow = 16'h0;
  logic [15:0] m_disp   = 16'h0;

  logic [6:0] glyph [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int idx, input logic blz);
    logic [3:0] nib;
    nib = v[idx*4 +: 4];
    if (blz && idx >= 1 && (v >> (4 * idx)) == 16'h0) return 7'h7f;
    if (nib > 4'd9) return 7'b0111111;
    return glyph[nib];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  // One running cycle: drive inputs, clock, predict, sample #1 after the edge.
  task automatic cycle(input bit ld, input logic [15:0] val);
    int cnt, idx;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_fd;
    rst_n = 1'b1;
    load  = ld;
    {thousands, hundreds, tens, ones} = val;
    @(posedge clk);
    cnt   = k % RD;
    idx   = (k / RD) % 4;
    e_an  = (cnt >= BC) ? ~(4'b0001 << idx) : 4'hf;
    e_seg = (cnt >= BC) ? exp_seg(m_disp, idx, blank_lz) : 7'h7f;
    e_fd  = (idx == 3) && (cnt == RD - 1);
    if (cnt == RD - 1) m_disp = m_shadow;
    if (ld) m_shadow = val;
    k++;
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("dp", 32'(dp), 32'h1);
    load = 1'b0;
  endtask

  task automatic rst_cycle();
    rst_n = 1'b0;
    load  = 1'b0;
    @(posedge clk);
    k = 0;
    m_shadow = 16'h0;
    m_disp   = 16'h0;
    #1;
    check("rst_an", 32'(an), 32'hf);
    check("rst_seg", 32'(seg), 32'h7f);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_dp", 32'(dp), 32'h1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0);
  endtask

  initial begin
    // Reset, then first slot shows "0" on the ones digit after the gap.
    for (int i = 0; i < 3; i++) rst_cycle();
    run(RD);

    // Scan of 1,2,3,4 over two full frames plus settling.
    cycle(1'b1, 16'h1234);
    run(8 * RD + RD);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    cycle(1'b1, 16'h0042);
    run(5 * RD);
    cycle(1'b1, 16'h0000);
    run(5 * RD);
    blank_lz = 1'b0;
    run(4 * RD);

    // Invalid BCD in tens shows a dash and is never blanked.
    cycle(1'b1, 16'h00c5);
    blank_lz = 1'b1;
    run(5 * RD);
    blank_lz = 1'b0;
    run(4 * RD);

    // Load coinciding with a slot wrap: old value for one more slot.
    cycle(1'b1, 16'h9999);
    run(2 * RD);
    while (k % RD != RD - 1) cycle(1'b0, 16'h0);
    cycle(1'b1, 16'h5678);
    run(5 * RD);

    // Reset at cnt=5 of slot 2, then restart from idx 0 with shadow cleared.
    while (!(((k / RD) % 4 == 2) && (k % RD == 5))) cycle(1'b0, 16'h0);
    rst_cycle();
    run(5 * RD);

    // Random traffic including non-BCD nibbles, blank_lz toggles and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 399) == 0) rst_cycle();
      else cycle($urandom_range(0, 15) == 0, 16'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
